adc_capture_ctrl: RTL
=====================

Name: adc_capture_ctrl

Overview:
Capture controller between the RF data converter ADC stream and the PL-to-PS word splitter. On a software start command it captures a programmable number of 128-bit ADC words (8 x 16-bit samples each) into a local buffer FIFO. It then presents the words as a standard AXI-Stream to the PL-to-PS splitter. It reports busy, done, overflow and captured-word count to GPIO status.

Parameters:
fifo_addr_width, 9, log2 of buffer depth in 128-bit words (512).
len_width, 16, width of capture length and word counters.

Ports:
clk  in  1  fabric clock, same domain as ADC stream and splitter.
rst  in  1  asynchronous, active-low reset.
adc_tdata  in  128  ADC samples; sample i is at bits [16i+15:16i].
adc_tvalid  in  1  ADC word valid. No backpressure; the ADC never stalls.
capture_len  in  len_width  number of words per capture; sampled at start.
gpio_ctrl  in  16  control bits; indices come from the shared package.
m_axis_tdata  out  128  buffered word to the splitter.
m_axis_tvalid  out  1  buffer not empty.
m_axis_tready  in  1  splitter accepts the word.
busy  out  1  high in CAPTURE or DRAIN.
done  out  1  capture complete and buffer drained; sticky.
overflow  out  1  sticky: at least one word dropped because the buffer was full.
words_captured  out  len_width  ADC words counted in the current or last capture.

Behaviour:
- Reset (rst low, async): state IDLE, FIFO empty.
  - m_axis_tvalid=0, m_axis_tdata=0.
  - busy=0, done=0, overflow=0, words_captured=0.
  - Internal start-edge register = 0.
- Start event: rising edge of gpio_ctrl[adc_capture_start]. It is detected by a one-cycle-delayed copy of the bit. A level held high never retriggers.
- Flush: gpio_ctrl[adc_buffer_flush]=1 is synchronous and has the highest priority.
  - Empties the FIFO and returns to IDLE.
  - Clears done, overflow and words_captured.
  - Holds m_axis_tvalid=0 for as long as flush is high.
  - Start edges are ignored while flush is high.
- States:
  - IDLE: on a start event with capture_len!=0:
    - latch capture_len into len_reg;
    - clear words_captured, done and overflow;
    - go to CAPTURE.
    - A start event with capture_len==0 is ignored: state, done and overflow are unchanged.
  - CAPTURE: each cycle with adc_tvalid=1:
    - words_captured increments;
    - the word is written if the FIFO is not full, otherwise it is dropped and overflow is set (a dropped word still counts);
    - when words_captured reaches len_reg-1 and this cycle's word is accepted or dropped, go to DRAIN;
    - start events are ignored.
  - DRAIN: ignore adc_tvalid. When the FIFO is empty, go to DONE.
  - DONE: done=1. A new start event behaves as in IDLE. A flush returns to IDLE.
  - An illegal state encoding forces IDLE.
- Timing: the write path is registered. An ADC word sampled at edge N appears on m_axis_tdata with m_axis_tvalid=1 after edge N+2, provided the FIFO was empty.
- FIFO read:
  - First-word-fall-through; m_axis_tvalid = !empty.
  - A pop occurs only on m_axis_tvalid && m_axis_tready.
  - m_axis_tdata is stable while tvalid=1 and tready=0.
  - A simultaneous push and pop while full succeeds: the pop frees the slot and both take effect. Same for a push and pop while empty-plus-one.
  - Occupancy count width is fifo_addr_width+1. Pointers wrap modulo depth.
- The splitter raises tready one cycle after tvalid and holds it one cycle per 128-bit word. The block must tolerate tready pulsing without loss or duplication.
- Counter saturation: len_reg is at most 2^len_width-1 and words_captured never exceeds len_reg.
- busy = (state==CAPTURE || state==DRAIN).

Decomposition:
- Shared package rfsoc_config gains:
  - adc_capture_start (gpio bit index);
  - adc_word_width=128, adc_sample_width=16;
  - the capture state enum type.
  - The existing adc_buffer_flush index is reused.
- One sub-module: capture_fifo, a single-clock FWFT FIFO with full/empty flags and a synchronous clear, parameterised by width and address width.

Test Plan:
1. Reset, capture_len=4, start edge, 4 ADC words 0x...01 to 0x...04 with tready=1 -> output 01..04 in order. First tvalid 2 cycles after first write. words_captured=4, then done=1, busy=0.
2. capture_len=16, tready pulsed 1 cycle in every 5 (splitter pattern) -> all 16 words out exactly once, in order, data stable while stalled. done rises only after the last pop.
3. fifo_addr_width=2 (depth 4), capture_len=8, tready=0 -> FIFO holds words 1-4, words 5-8 dropped. overflow=1, words_captured=8. Releasing tready yields exactly words 1-4, then done=1.
4. Flush asserted mid-CAPTURE after 3 of 10 words -> next cycle m_axis_tvalid=0, state IDLE, words_captured=0, overflow=0. A later start captures a fresh 10 words correctly.
5. Start bit held high for 20 cycles after done; capture_len=0 on a separate edge -> no retrigger while held. The zero-length edge is ignored and done stays 1.
6. rst pulsed low asynchronously mid-DRAIN with 3 words buffered -> all outputs go to reset values immediately, FIFO empties, no stale word appears after reset release.

Source files
------------

// File: rtl/rfsoc_config.sv
// Shared RFSoC configuration package.
// Holds GPIO control bit indices, ADC word geometry and the capture FSM state type
// used by the ADC capture path.
package rfsoc_config;

  // GPIO control bit indices
  localparam int unsigned adc_buffer_flush  = 0;
  localparam int unsigned adc_capture_start = 1;

  // ADC stream geometry: one word carries 8 x 16-bit samples
  localparam int unsigned adc_word_width       = 128;
  localparam int unsigned adc_sample_width     = 16;
  localparam int unsigned adc_samples_per_word = adc_word_width / adc_sample_width;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDrain,
    StDone
  } capture_state_e;

endpackage

// File: rtl/capture_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous clear.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   clear             synchronous flush of all contents
//   push, wdata       write request and data (ignored when full unless popping)
//   pop               read request (ignored when empty)
//   rdata             head word, zero when empty
//   full, empty       occupancy flags
module capture_fifo #(
  parameter int unsigned width      = 128,
  parameter int unsigned addr_width = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned depth = 2 ** addr_width;

  logic [width-1:0]      mem [depth];
  logic [addr_width-1:0] wr_ptr_q;
  logic [addr_width-1:0] rd_ptr_q;
  logic [addr_width:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (addr_width + 1)'(depth));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally modulo depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + addr_width'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + addr_width'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (addr_width + 1)'(1);
        2'b01:   count_q <= count_q - (addr_width + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller.
// On a rising edge of the software start bit, captures capture_len ADC words into a
// buffer FIFO, then streams them out as AXI-Stream to the PL-to-PS splitter.
// Ports:
//   clk, rst                     fabric clock, asynchronous active-low reset
//   adc_tdata, adc_tvalid        ADC word stream (no backpressure)
//   capture_len                  words per capture, latched at start
//   gpio_ctrl                    software control bits (start, flush)
//   m_axis_tdata/tvalid/tready   buffered output stream
//   busy, done, overflow         status (done and overflow are sticky)
//   words_captured               ADC words counted in current or last capture
module adc_capture_ctrl
  import rfsoc_config::*;
#(
  parameter int unsigned fifo_addr_width = 9,
  parameter int unsigned len_width       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [adc_word_width-1:0] adc_tdata,
  input  logic                      adc_tvalid,
  input  logic [len_width-1:0]      capture_len,
  input  logic [15:0]               gpio_ctrl,
  output logic [adc_word_width-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [len_width-1:0]      words_captured
);

  capture_state_e            state_q;
  logic [len_width-1:0]      len_q;
  logic [len_width-1:0]      words_q;
  logic                      overflow_q;
  logic                      start_q;
  // Two-stage registered write path: sample, then hold, then FIFO write.
  logic                      s1_vld_q;
  logic [adc_word_width-1:0] s1_data_q;
  logic                      s2_vld_q;
  logic [adc_word_width-1:0] s2_data_q;

  logic                      flush;
  logic                      start_bit;
  logic                      start_evt;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;
  logic [adc_word_width-1:0] fifo_rdata;
  logic                      unused_gpio;

  assign flush       = gpio_ctrl[adc_buffer_flush];
  assign start_bit   = gpio_ctrl[adc_capture_start];
  assign start_evt   = start_bit && !start_q && !flush;
  assign unused_gpio = ^gpio_ctrl;

  assign m_axis_tvalid  = !fifo_empty && !flush;
  assign m_axis_tdata   = fifo_rdata;
  assign fifo_pop       = m_axis_tvalid && m_axis_tready;
  assign busy           = (state_q == StCapture) || (state_q == StDrain);
  assign done           = (state_q == StDone);
  assign overflow       = overflow_q;
  assign words_captured = words_q;

  capture_fifo #(
    .width      (adc_word_width),
    .addr_width (fifo_addr_width)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (s2_vld_q),
    .wdata (s2_data_q),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      words_q    <= '0;
      overflow_q <= 1'b0;
      start_q    <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_data_q  <= '0;
    end else if (flush) begin
      // Tracking the start bit during flush means a level raised under flush never fires.
      state_q    <= StIdle;
      words_q    <= '0;
      overflow_q <= 1'b0;
      start_q    <= start_bit;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
    end else begin
      start_q   <= start_bit;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= s1_vld_q;
      s2_data_q <= s1_data_q;
      // Word reaching the FIFO with no room is dropped.
      if (s2_vld_q && fifo_full && !fifo_pop) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        StIdle, StDone: begin
          if (start_evt && (capture_len != '0)) begin
            len_q      <= capture_len;
            words_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= StCapture;
          end
        end
        StCapture: begin
          if (adc_tvalid) begin
            s1_vld_q  <= 1'b1;
            s1_data_q <= adc_tdata;
            words_q   <= words_q + len_width'(1);
            if (words_q == len_q - len_width'(1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // Wait for in-flight pipeline words too, not just the FIFO.
          if (fifo_empty && !s1_vld_q && !s2_vld_q) begin
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
